// File: rtl/wb_misc_io_pkg.sv
// ============================================================================
// wb_misc_io_pkg - register map, limits and interrupt bit helpers for wb_misc_io
// rev 1.0
// ============================================================================
`default_nettype none

package wb_misc_io_pkg;

   typedef logic [3:0] reg_addr_t;

   localparam reg_addr_t REG_LED0       = 4'h0;
   localparam reg_addr_t REG_BUTTONS    = 4'h8;
   localparam reg_addr_t REG_INT_ENABLE = 4'h9;
   localparam reg_addr_t REG_INT_STATUS = 4'hA;
   localparam reg_addr_t REG_MIC        = 4'hB;
   localparam reg_addr_t REG_FADE_DIV   = 4'hC;

   localparam int MAX_LEDS = 8;
   localparam int MAX_BTNS = 8;

   function automatic int int_bit_rise(input int i);
      return 2 * i;
   endfunction

   function automatic int int_bit_fall(input int i);
      return 2 * i + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_misc_io_btn_debounce.sv
// ============================================================================
// btn_debounce - 2-flop synchroniser, stability counter and edge pulses
// rev 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic state_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          flip;

   always_comb begin
      sync1_d = btn_i;
      sync2_d = sync1_q;
      flip    = (sync2_q != state_q) && (cnt_q == CNT_MAX);
      state_d = state_q ^ flip;
      // any sample agreeing with the accepted state restarts the stability count
      if ((sync2_q == state_q) || flip)
         cnt_d = '0;
      else
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state_o = state_q;
   assign rise_o  = flip & ~state_q;
   assign fall_o  = flip & state_q;

endmodule

`default_nettype wire

// File: rtl/wb_misc_io.sv
// ============================================================================
// wb_misc_io - Wishbone PWM LEDs, debounced buttons with W1C irqs, mic readback
// Optional fading of LED intensity with macro WB_MISC_IO_FADE_EN.  rev 1.0
// ============================================================================
`default_nettype none

module wb_misc_io
   import wb_misc_io_pkg::*;
#(
   parameter int AW              = 32,
   parameter int DW              = 32,
   parameter int NUM_LEDS        = 3,
   parameter int NUM_BTNS        = 2,
   parameter int PWM_BITS        = 8,
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic                wb_clk_i,
   input  logic                wb_reset_i,
   input  logic [AW-1:0]       wb_adr_i,
   input  logic [DW-1:0]       wb_dat_i,
   output logic [DW-1:0]       wb_dat_o,
   input  logic                wb_we_i,
   input  logic [DW/8-1:0]     wb_sel_i,
   output logic                wb_ack_o,
   input  logic                wb_cyc_i,
   input  logic                wb_stb_i,
   output logic [NUM_LEDS-1:0] leds,
   input  logic [NUM_BTNS-1:0] buttons,
   input  logic [15:0]         audio,
   output logic                irq
);

   localparam int NI = 2 * NUM_BTNS;

   logic                stb_valid, wr_en;
   reg_addr_t           reg_addr;
   logic [15:0]         byte_mask16;
   logic [NI-1:0]       byte_mask;
   logic [DW-1:0]       rd_data;

   logic                ack_q, ack_d;
   logic [DW-1:0]       dat_q, dat_d;
   logic [PWM_BITS-1:0] intensity_q [NUM_LEDS];
   logic [PWM_BITS-1:0] intensity_d [NUM_LEDS];
   logic [PWM_BITS-1:0] eff         [NUM_LEDS];
   logic [NI-1:0]       int_en_q, int_en_d, int_st_q, int_st_d, set_pulse;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [NUM_LEDS-1:0] leds_q, leds_d;

   logic [NUM_BTNS-1:0] btn_state, btn_rise, btn_fall;

   logic unused_inputs;
   assign unused_inputs = ^{wb_adr_i, wb_dat_i, wb_sel_i};

   assign reg_addr    = wb_adr_i[3:0];
   assign stb_valid   = wb_cyc_i & wb_stb_i & ~ack_q;
   assign wr_en       = stb_valid & wb_we_i;
   assign byte_mask16 = {{8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
   assign byte_mask   = byte_mask16[NI-1:0];

   for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (wb_clk_i),
         .rst    (wb_reset_i),
         .btn_i  (buttons[b]),
         .state_o(btn_state[b]),
         .rise_o (btn_rise[b]),
         .fall_o (btn_fall[b])
      );
   end

   always_comb begin
      set_pulse = '0;
      for (int b = 0; b < NUM_BTNS; b++) begin
         set_pulse[int_bit_rise(b)] = btn_rise[b];
         set_pulse[int_bit_fall(b)] = btn_fall[b];
      end
   end

`ifdef WB_MISC_IO_FADE_EN
   logic [15:0]         fade_div_q, fade_div_d, presc_q, presc_d;
   logic                tick;
   logic [PWM_BITS-1:0] eff_q [NUM_LEDS];
   logic [PWM_BITS-1:0] eff_d [NUM_LEDS];

   always_comb begin
      // >= keeps the prescaler from running the long way round after FADE_DIV shrinks
      tick    = (presc_q >= fade_div_q);
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
      fade_div_d = fade_div_q;
      if (wr_en && reg_addr == REG_FADE_DIV)
         fade_div_d = (fade_div_q & ~byte_mask16) | (wb_dat_i[15:0] & byte_mask16);
      for (int i = 0; i < NUM_LEDS; i++) begin
         eff_d[i] = eff_q[i];
         if (tick && eff_q[i] < intensity_q[i])
            eff_d[i] = eff_q[i] + PWM_BITS'(1);
         else if (tick && eff_q[i] > intensity_q[i])
            eff_d[i] = eff_q[i] - PWM_BITS'(1);
         eff[i] = eff_q[i];
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
      if (wb_reset_i) begin
         fade_div_q <= '0;
         presc_q    <= '0;
         for (int i = 0; i < NUM_LEDS; i++) eff_q[i] <= '0;
      end else begin
         fade_div_q <= fade_div_d;
         presc_q    <= presc_d;
         for (int i = 0; i < NUM_LEDS; i++) eff_q[i] <= eff_d[i];
      end
   end
`else
   always_comb begin
      for (int i = 0; i < NUM_LEDS; i++) eff[i] = intensity_q[i];
   end
`endif

   always_comb begin
      rd_data = '0;
      case (reg_addr)
         REG_BUTTONS:    rd_data[NUM_BTNS-1:0] = btn_state;
         REG_INT_ENABLE: rd_data[NI-1:0] = int_en_q;
         REG_INT_STATUS: rd_data[NI-1:0] = int_st_q;
         REG_MIC:        rd_data = DW'($signed(audio));
`ifdef WB_MISC_IO_FADE_EN
         REG_FADE_DIV:   rd_data[15:0] = fade_div_q;
`endif
         default: begin
            for (int i = 0; i < NUM_LEDS; i++)
               if (reg_addr == REG_LED0 + 4'(i)) rd_data[PWM_BITS-1:0] = intensity_q[i];
         end
      endcase
   end

   always_comb begin
      ack_d = stb_valid;
      dat_d = (stb_valid && !wb_we_i) ? rd_data : '0;

      for (int i = 0; i < NUM_LEDS; i++) begin
         intensity_d[i] = intensity_q[i];
         if (wr_en && wb_sel_i[0] && reg_addr == REG_LED0 + 4'(i))
            intensity_d[i] = wb_dat_i[PWM_BITS-1:0];
      end

      int_en_d = int_en_q;
      if (wr_en && reg_addr == REG_INT_ENABLE)
         int_en_d = (int_en_q & ~byte_mask) | (wb_dat_i[NI-1:0] & byte_mask);

      // clear first, then OR in new edges so a coincident set survives the W1C
      int_st_d = int_st_q;
      if (wr_en && reg_addr == REG_INT_STATUS)
         int_st_d = int_st_q & ~(wb_dat_i[NI-1:0] & byte_mask);
      int_st_d = int_st_d | set_pulse;

      pwm_d = pwm_q + PWM_BITS'(1);
      for (int i = 0; i < NUM_LEDS; i++) leds_d[i] = (eff[i] > pwm_q);
   end

   always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
      if (wb_reset_i) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         int_en_q <= '0;
         int_st_q <= '0;
         pwm_q    <= '0;
         leds_q   <= '0;
         for (int i = 0; i < NUM_LEDS; i++) intensity_q[i] <= '0;
      end else begin
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         int_en_q <= int_en_d;
         int_st_q <= int_st_d;
         pwm_q    <= pwm_d;
         leds_q   <= leds_d;
         for (int i = 0; i < NUM_LEDS; i++) intensity_q[i] <= intensity_d[i];
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;
   assign leds     = leds_q;
   assign irq      = |(int_en_q & int_st_q);

endmodule

`default_nettype wire

// File: tb/tb_wb_misc_io.sv
// ============================================================================
// tb_wb_misc_io - directed scoreboard bench for wb_misc_io (DEBOUNCE_CYCLES=16)
// rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_misc_io;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] adr = '0;
   logic [31:0] wdat = '0;
   logic [31:0] rdat;
   logic        we = 1'b0;
   logic [3:0]  sel = '0;
   logic        ack;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic [2:0]  leds;
   logic [1:0]  buttons = '0;
   logic [15:0] audio = '0;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   wb_misc_io #(
      .AW(32), .DW(32), .NUM_LEDS(3), .NUM_BTNS(2), .PWM_BITS(8), .DEBOUNCE_CYCLES(16)
   ) dut (
      .wb_clk_i  (clk),
      .wb_reset_i(rst),
      .wb_adr_i  (adr),
      .wb_dat_i  (wdat),
      .wb_dat_o  (rdat),
      .wb_we_i   (we),
      .wb_sel_i  (sel),
      .wb_ack_o  (ack),
      .wb_cyc_i  (cyc),
      .wb_stb_i  (stb),
      .leds      (leds),
      .buttons   (buttons),
      .audio     (audio),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // single access; caller is positioned just after a rising edge
   task automatic wb_access(input logic w, input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] r);
      logic got = 1'b0;
      cyc = 1'b1; stb = 1'b1; we = w; adr = {28'd0, a}; wdat = d; sel = s;
      for (int k = 0; k < 8 && !got; k++) begin
         @(posedge clk);
         #1;
         got = ack;
      end
      r = rdat;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      check("ack_seen", {31'd0, got}, 32'd1);
   endtask

   task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
      logic [31:0] r;
      wb_access(1'b1, a, d, s, r);
   endtask

   task automatic wb_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] r;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      wb_access(1'b0, a, 32'd0, 4'hF, r);
      check(tag_q.pop_front(), r, exp_q.pop_front());
   endtask

   task automatic count_high(input int idx, output int n);
      n = 0;
      for (int k = 0; k < 256; k++) begin
         @(posedge clk);
         #1;
         n += int'(leds[idx]);
      end
   endtask

   initial begin
      int n;
      logic got;

      // reset state while reset is held
      #12;
      check("rst_ack",  {31'd0, ack}, 32'd0);
      check("rst_dat",  rdat, 32'd0);
      check("rst_leds", {29'd0, leds}, 32'd0);
      check("rst_irq",  {31'd0, irq}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      tick(2);

      wb_read(4'h1, 32'd0, "led1_reset");

      // PWM duty
      wb_write(4'h1, 32'h40);
      wb_read(4'h1, 32'h40, "led1_rb");
      tick(300);
      count_high(1, n);
      check("duty_40", n, 32'd64);
      wb_write(4'h1, 32'h00);
      tick(300);
      count_high(1, n);
      check("duty_00", n, 32'd0);
      wb_write(4'h1, 32'hFF);
      tick(300);
      count_high(1, n);
      check("duty_ff", n, 32'd255);

      // unimplemented LED index and sel[0] gating
      wb_write(4'h5, 32'h12);
      wb_read(4'h5, 32'd0, "led5_absent");
      wb_write(4'h2, 32'h33, 4'hE);
      wb_read(4'h2, 32'd0, "led2_sel_gated");

      // glitch shorter than the debounce window is rejected
      buttons[0] = 1'b1;
      tick(10);
      buttons[0] = 1'b0;
      tick(30);
      wb_read(4'h8, 32'd0, "btn_glitch");
      wb_read(4'hA, 32'd0, "st_glitch");

      // accepted rise: status and irq follow 2+16 clocks after the pin
      wb_write(4'h9, 32'h1);
      tick(3);
      buttons[0] = 1'b1;
      tick(17);
      check("irq_before", {31'd0, irq}, 32'd0);
      tick(1);
      check("irq_rise", {31'd0, irq}, 32'd1);
      wb_read(4'h8, 32'h1, "btn_state");
      wb_read(4'hA, 32'h1, "st_rise");

      // W1C sel gating, then real clear
      wb_write(4'hA, 32'h1, 4'h0);
      wb_read(4'hA, 32'h1, "st_sel_gated");
      wb_write(4'hA, 32'h1);
      wb_read(4'hA, 32'h0, "st_cleared");
      check("irq_cleared", {31'd0, irq}, 32'd0);

      // falling edge latches regardless of enable, irq stays low
      buttons[0] = 1'b0;
      tick(25);
      wb_read(4'hA, 32'h2, "st_fall");
      check("irq_masked", {31'd0, irq}, 32'd0);
      wb_write(4'hA, 32'h2);

      // set and W1C of bit0 in the same cycle: set wins
      tick(3);
      buttons[0] = 1'b1;
      tick(17);
      wb_write(4'hA, 32'h1);
      wb_read(4'hA, 32'h1, "st_set_wins");
      check("irq_set_wins", {31'd0, irq}, 32'd1);

      // enable byte gating
      wb_write(4'h9, 32'hF, 4'h0);
      wb_read(4'h9, 32'h1, "en_sel_gated");
      wb_write(4'h9, 32'hF);
      wb_read(4'h9, 32'hF, "en_full");
      wb_write(4'h9, 32'h1);

      // mic sign extension, unmapped read
      audio = 16'h8001;
      wb_read(4'hB, 32'hFFFF8001, "mic_neg");
      audio = 16'h1234;
      wb_read(4'hB, 32'h00001234, "mic_pos");
      wb_read(4'hE, 32'd0, "unmapped");

      // held strobe acks every other cycle
      tick(1);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
      tick(1); check("held_ack0", {31'd0, ack}, 32'd1);
      tick(1); check("held_ack1", {31'd0, ack}, 32'd0);
      tick(1); check("held_ack2", {31'd0, ack}, 32'd1);
      cyc = 1'b0; stb = 1'b0;
      tick(2);

`ifdef WB_MISC_IO_FADE_EN
      wb_write(4'hC, 32'd3);
      wb_read(4'hC, 32'd3, "fade_div");
      wb_write(4'h0, 32'd10);
      wb_read(4'h0, 32'd10, "fade_target");
      tick(60);
      count_high(0, n);
      check("fade_duty", n, 32'd10);
      wb_write(4'h2, 32'd200);
      tick(50);
`else
      wb_write(4'hC, 32'h5);
      wb_read(4'hC, 32'd0, "fade_absent");
`endif

      // reset mid-transaction: everything drops immediately
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         tick(1);
         got = leds[1];
      end
      check("pre_rst_led", {31'd0, got}, 32'd1);
      check("pre_rst_irq", {31'd0, irq}, 32'd1);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h1;
      tick(1);
      rst = 1'b1;
      #1;
      check("mid_rst_ack",  {31'd0, ack}, 32'd0);
      check("mid_rst_dat",  rdat, 32'd0);
      check("mid_rst_leds", {29'd0, leds}, 32'd0);
      check("mid_rst_irq",  {31'd0, irq}, 32'd0);
      cyc = 1'b0; stb = 1'b0;
      buttons = '0;
      tick(2);
      rst = 1'b0;
      tick(2);
      wb_read(4'h1, 32'd0, "led1_after_rst");
      wb_read(4'hA, 32'd0, "st_after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
